// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for DIGITS common-anode 7-segment
// digits sharing one active-low segment bus.
//
// A packed hex value is captured on a one-cycle load strobe into a pending
// register and only moved into the display register on a frame boundary
// (the last digit's slot ending). This means a frame never mixes old and new
// nibbles. Each digit slot is REFRESH_DIV cycles long. The first cycle of every
// slot is a blank cycle (all anodes off), which prevents ghosting while the
// segment bus changes.
//
// Optional build macro SEG7_LEAD_ZERO_BLANK_EN: when defined, digits above the
// most significant non-zero nibble of the display register are blanked as if
// blank_mask were set for them. Digit 0 is always shown. When undefined, only
// blank_mask darkens digits.

module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [0:6]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [0:6]       SEG_OFF  = 7'b1111111;

  typedef enum logic {
    ST_BLANK,
    ST_SCAN
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [4*DIGITS-1:0]    disp;
  logic [4*DIGITS-1:0]    pend;
  logic                   flag;

  logic                   tick;
  logic                   boundary;
  logic [DIGITS-1:0]      eff_mask;
  logic [3:0]             cur_nib;
  logic                   cur_dark;
  logic [0:6]             cur_seg;
  logic [DIGITS-1:0]      an_on;

  // Active-low a..g pattern for one hex nibble.
  function automatic logic [0:6] hex_decode(input logic [3:0] nib);
    logic [0:6] s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // A slot ends on the prescaler's last count; the last digit's slot end is a frame boundary.
  assign tick     = (cnt == LAST_CNT);
  assign boundary = tick && (state == ST_SCAN) && (idx == LAST_IDX);

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_mask;
  logic              upper_nz;

  // Dark every digit above the most significant non-zero nibble; digit 0 always shows.
  always_comb begin
    lz_mask  = '0;
    upper_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_nz   = upper_nz | (disp[4*i +: 4] != 4'h0);
      lz_mask[i] = ~upper_nz;
    end
  end

  assign eff_mask = blank_mask | lz_mask;
`else
  assign eff_mask = blank_mask;
`endif

  // Select the nibble and blanking bit of the digit currently being scanned.
  always_comb begin
    cur_nib  = 4'h0;
    cur_dark = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib  = disp[4*i +: 4];
        cur_dark = eff_mask[i];
      end
    end
  end

  assign cur_seg = cur_dark ? SEG_OFF : hex_decode(cur_nib);
  assign an_on   = ~(DIGITS'(1) << idx);

  // Prescaler: free-running 0..REFRESH_DIV-1 slot timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Scan FSM: one blank cycle, then the digit stays lit until the slot ends; outputs refresh every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BLANK;
      idx   <= '0;
      seg   <= SEG_OFF;
      an    <= '1;
    end else begin
      case (state)
        ST_BLANK: begin
          state <= ST_SCAN;
          an    <= an_on;
          seg   <= cur_seg;
        end
        ST_SCAN: begin
          if (tick) begin
            state <= ST_BLANK;
            an    <= '1;
            seg   <= SEG_OFF;
            if (idx == LAST_IDX) begin
              idx <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            an  <= an_on;
            seg <= cur_seg;
          end
        end
        default: begin
          state <= ST_BLANK;
          an    <= '1;
          seg   <= SEG_OFF;
        end
      endcase
    end
  end

  // Load path: load is a single-cycle strobe with no back-pressure. Every strobe
  // overwrites pending (last load wins). The display register changes only on a
  // frame boundary. A strobe on the boundary cycle goes straight to the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp       <= '0;
      pend       <= '0;
      flag       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (load) begin
        pend <= value;
      end
      if (boundary) begin
        if (load) begin
          disp <= value;
        end else if (flag) begin
          disp <= pend;
        end
        flag <= 1'b0;
      end else if (load) begin
        flag <= 1'b1;
      end
    end
  end

endmodule
